// File: rtl/exe2mem_pipe_buf.sv
// -----------------------------------------------------------------------------
// exe2mem_pipe_buf
//
// Elastic EXE->MEM pipeline buffer. A DEPTH-entry circular FIFO carries the
// six EXE->MEM payload fields with a valid/ready handshake on each side and a
// pipeline flush. MEM back-pressure reaches EXE only through in_ready_o. That
// signal is decoded from the registered occupancy, so there is no combinational
// path from out_ready_i to in_ready_o. There is also no in->out bypass.
//
// Ports
//   clk             core clock, rising-edge
//   rstn            asynchronous active-low reset
//   flush_i         drop every buffered entry and the same-cycle input
//   in_valid_i      EXE offers a payload
//   in_ready_o      buffer has room (registered occupancy < DEPTH)
//   in_*_i          EXE payload: exe_out, op3, rd, mem_ctrl, gpr_ctrl, csr_ctrl
//   out_valid_o     head entry is valid
//   out_ready_i     MEM consumes the head entry
//   out_*_o         head entry payload, forced to 0 while out_valid_o = 0
//   count_o         registered occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module exe2mem_pipe_buf #(
  parameter int DATA_WIDTH     = 32,
  parameter int RF_ADDR_WIDTH  = 5,
  parameter int MEM_CTRL_WIDTH = 4,
  parameter int GPR_CTRL_WIDTH = 3,
  parameter int CSR_CTRL_WIDTH = 2,
  parameter int DEPTH          = 2
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         flush_i,
  // EXE side
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic [DATA_WIDTH-1:0]        in_exe_out_i,
  input  logic [DATA_WIDTH-1:0]        in_op3_i,
  input  logic [RF_ADDR_WIDTH-1:0]     in_rd_i,
  input  logic [MEM_CTRL_WIDTH-1:0]    in_mem_ctrl_i,
  input  logic [GPR_CTRL_WIDTH-1:0]    in_gpr_ctrl_i,
  input  logic [CSR_CTRL_WIDTH-1:0]    in_csr_ctrl_i,
  // MEM side
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [DATA_WIDTH-1:0]        out_exe_out_o,
  output logic [DATA_WIDTH-1:0]        out_op3_o,
  output logic [RF_ADDR_WIDTH-1:0]     out_rd_o,
  output logic [MEM_CTRL_WIDTH-1:0]    out_mem_ctrl_o,
  output logic [GPR_CTRL_WIDTH-1:0]    out_gpr_ctrl_o,
  output logic [CSR_CTRL_WIDTH-1:0]    out_csr_ctrl_o,
  // occupancy
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  // A single-entry buffer still gets a 1-bit pointer that simply stays at 0.
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // The read mux spans every pointer code. Codes at or above DEPTH are never
  // reached; they are padded so the index is always in range.
  localparam int SLOTS = 1 << PTR_W;
  localparam int PAY_W = 2 * DATA_WIDTH + RF_ADDR_WIDTH + MEM_CTRL_WIDTH
                       + GPR_CTRL_WIDTH + CSR_CTRL_WIDTH;

  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_next;

  logic             push;
  logic             pop;

  logic [PAY_W-1:0] in_payload;
  logic [PAY_W-1:0] head_payload;
  logic [PAY_W-1:0] out_payload;
  logic [PAY_W-1:0] slot [SLOTS];

  // Explicit wrap at DEPTH-1. Truncating the pointer bits would be wrong for
  // DEPTH = 3.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    if (ptr == LAST_PTR) begin
      return '0;
    end
    return ptr + PTR_W'(1);
  endfunction

  // ---------------------------------------------------------------------------
  // Handshake decode
  // ---------------------------------------------------------------------------
  // Ready comes only from registered occupancy. A pop in the same cycle does
  // not free a slot for the incoming payload, so a full buffer refuses input
  // even when MEM is draining it.
  assign in_ready_o  = (count_reg < FULL_CNT);
  assign out_valid_o = (count_reg != '0);

  // Flush overrides both sides. EXE may see in_ready_o = 1 in a flush cycle,
  // but its payload is still dropped.
  assign push = in_valid_i  & in_ready_o  & ~flush_i;
  assign pop  = out_valid_o & out_ready_i & ~flush_i;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    count_next  = count_reg;
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;

    if (flush_i) begin
      count_next  = '0;
      wr_ptr_next = '0;
      rd_ptr_next = '0;
    end else begin
      if (push) begin
        wr_ptr_next = ptr_inc(wr_ptr_reg);
      end
      if (pop) begin
        rd_ptr_next = ptr_inc(rd_ptr_reg);
      end
      unique case ({push, pop})
        2'b10:   count_next = count_reg + CNT_ONE;
        2'b01:   count_next = count_reg - CNT_ONE;
        default: count_next = count_reg;  // idle, or push and pop together
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_reg  <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      count_reg  <= count_next;
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  assign in_payload = {in_exe_out_i, in_op3_i, in_rd_i,
                       in_mem_ctrl_i, in_gpr_ctrl_i, in_csr_ctrl_i};

  // Each entry is cleared by reset. A flush only rewinds the pointers and
  // leaves stale data behind, which the output mask hides.
  genvar gi;
  generate
    for (gi = 0; gi < SLOTS; gi++) begin : gen_slot
      if (gi < DEPTH) begin : gen_entry
        logic [PAY_W-1:0] entry_reg;

        always_ff @(posedge clk or negedge rstn) begin
          if (!rstn) begin
            entry_reg <= '0;
          end else if (push && (wr_ptr_reg == PTR_W'(gi))) begin
            entry_reg <= in_payload;
          end
        end

        assign slot[gi] = entry_reg;
      end else begin : gen_pad
        assign slot[gi] = '0;
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Head read and output mask
  // ---------------------------------------------------------------------------
  assign head_payload = slot[rd_ptr_reg];

  // Outputs read as all-zero while the buffer is empty. MEM then never sees a
  // stale or flushed payload, even if it ignores out_valid_o.
  assign out_payload = out_valid_o ? head_payload : '0;

  assign {out_exe_out_o, out_op3_o, out_rd_o,
          out_mem_ctrl_o, out_gpr_ctrl_o, out_csr_ctrl_o} = out_payload;

  assign count_o = count_reg;

endmodule
